bitty_ctrl_fsm: RTL and testbench
=================================

// Module: bitty_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer downstream of the fetch unit. It waits out the
//  instruction-memory read latency, latches the fetched word into the IR and
//  decodes it. It drives the register-file/ALU enables for one instruction, then
//  pulses pc_en so the PC loads new_pc from the branch logic. One instr at a time.
// PARAMETERS
//  MEM_LAT   1    cycles from PC update to valid instr_in (1..7)
//  INSTR_W   16   instruction width; fields below assume 16
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  run        in   1   level; 1 = keep executing, 0 = park in IDLE at next boundary
//  instr_in   in   16  instruction word from instruction memory
//  pc_en      out  1   one-cycle pulse: PC loads branch-logic new_pc
//  ir         out  16  latched instruction (feeds branch logic and datapath)
//  mux_sel    out  4   datapath bus select: 0-7 = R0-R7, 8 = imm8 (zero-ext)
//  imm8       out  8   ir[12:5], valid while ir holds an I-type
//  alu_sel    out  3   ALU op = ir[4:2]; held through EXEC
//  en_s       out  1   load ALU operand-A register
//  en_c       out  1   load ALU result register (last_alu_result)
//  en_rf      out  8   one-hot register-file write enable
//  busy       out  1   1 in every state except IDLE
//  done       out  1   one-cycle pulse when an instruction retires
//  illegal    out  1   sticky; set on format 2'b11, cleared by reset only
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ir=0, lat_cnt=0, all enables/pulses 0,
//   mux_sel=0, illegal=0. Release mid-instruction discards it; PC is untouched.
//  Decode: fmt=ir[1:0]; rx=ir[15:13]; ry=ir[12:10]. 00 R-type, 01 I-type,
//   10 branch, 11 illegal.
//  States and transitions (one per clock unless noted):
//   IDLE   : run=1 -> FETCH, lat_cnt=MEM_LAT-1.
//   FETCH  : wait for memory; lat_cnt!=0 -> decrement, stay; ==0 -> LOAD.
//   LOAD   : ir<=instr_in. -> READ_A (fmt 00/01), PC_UPD (fmt 10),
//            PC_UPD with illegal<=1 (fmt 11).
//   READ_A : mux_sel=rx, en_s=1 -> EXEC.
//   EXEC   : mux_sel=ry (00) or 8 (01), alu_sel=ir[4:2], en_c=1 -> WB.
//   WB     : en_rf[rx]=1 (result bus selected by datapath) -> PC_UPD.
//   PC_UPD : pc_en=1, done=1; run=1 -> FETCH (reload lat_cnt), run=0 -> IDLE.
//  Latency: R/I-type = MEM_LAT+5 cycles IDLE-exit to done; branch/illegal MEM_LAT+2.
//  Branch decision is made by the branch logic from ir and last_alu_result during
//   PC_UPD; this block only times pc_en. Branch never writes en_rf or en_c.
//  Enables (pc_en, en_s, en_c, en_rf, done) are decoded from the registered state:
//   high exactly one cycle per visit, never two at once except pc_en+done.
//  run is sampled only in IDLE and PC_UPD; dropping run mid-instruction finishes
//   that instruction before parking.
//  ir changes only in LOAD, so new_pc is stable throughout PC_UPD.
//  Illegal instructions retire as no-ops (PC+1 via branch logic); illegal stays 1.
//  Out-of-range MEM_LAT is a elaboration error.
// TESTING
//  1 run=1, instr 16'h2400 ADD R1,R1 (fmt00), MEM_LAT=1 -> en_s@t3, en_c@t4,
//    en_rf=8'h02@t5, pc_en+done@t6 (t0 = first clk with run).
//  2 I-type rx=R3, imm8=8'h2A (16'h6545) -> EXEC mux_sel=8, imm8=8'h2A,
//    en_rf=8'h08.
//  3 Branch fmt10 (16'h0A52) -> LOAD then PC_UPD; en_s/en_c/en_rf stay 0,
//    done 2 cycles after FETCH exit.
//  4 instr 16'hFFFF -> illegal=1, pc_en pulse, no en_rf; next legal instr runs,
//    illegal still 1.
//  5 assert reset asynchronously in EXEC -> all outputs 0 same cycle, state IDLE,
//    no pc_en.
//  6 run drops during READ_A -> instruction completes, done pulses, busy=0 next
//    cycle; MEM_LAT=3 repeat of 1 -> every event shifts +2 cycles.

Source files
------------

// File: rtl/bitty_ctrl_fsm.sv
// Multi-cycle control sequencer: waits out imem latency, latches/decodes IR, sequences RF/ALU enables, pulses pc_en.
// Latency: R/I-type MEM_LAT+5 cycles from IDLE exit to done; branch/illegal MEM_LAT+2.
// Backpressure: none; run is a level sampled only in IDLE and PC_UPD, so an instruction in flight always retires.
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   run                 : 1 = keep executing, 0 = park in IDLE at the next instruction boundary
//   instr_in            : instruction word from instruction memory
//   pc_en               : one-cycle pulse, PC loads new_pc from branch logic
//   ir                  : latched instruction
//   mux_sel, imm8       : datapath bus select (0-7 = R0-R7, 8 = imm8) and zero-extended immediate
//   alu_sel             : ALU op field ir[4:2]
//   en_s, en_c, en_rf   : operand-A load, result load, one-hot RF write enable
//   busy, done, illegal : not-IDLE, retire pulse, sticky illegal-format flag
module bitty_ctrl_fsm #(
  parameter int MEM_LAT = 1,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               pc_en,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         mux_sel,
  output logic [7:0]         imm8,
  output logic [2:0]         alu_sel,
  output logic               en_s,
  output logic               en_c,
  output logic [7:0]         en_rf,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
    $error("bitty_ctrl_fsm: MEM_LAT must be in 1..7");
  end
  if (INSTR_W != 16) begin : g_bad_instr_w
    $error("bitty_ctrl_fsm: field decode assumes INSTR_W == 16");
  end

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_READ_A = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_PC_UPD = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [2:0]           lat_cnt_q, lat_cnt_d;
  logic                 illegal_q, illegal_d;

  logic [1:0] fmt;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [1:0] in_fmt;

  assign fmt    = ir_q[1:0];
  assign rx     = ir_q[15:13];
  assign ry     = ir_q[12:10];
  assign in_fmt = instr_in[1:0];

  // State register (all flops)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      lat_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      lat_cnt_q <= lat_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    lat_cnt_d = lat_cnt_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d   = S_FETCH;
          lat_cnt_d = LAT_INIT;
        end
      end
      S_FETCH: begin
        if (lat_cnt_q != 3'd0) lat_cnt_d = lat_cnt_q - 3'd1;
        else                   state_d   = S_LOAD;
      end
      S_LOAD: begin
        // The only place ir changes, so new_pc is stable through PC_UPD.
        ir_d = instr_in;
        if (in_fmt == FMT_R || in_fmt == FMT_I) begin
          state_d = S_READ_A;
        end else begin
          state_d = S_PC_UPD;
          // Illegal words retire as no-ops; the flag stays until reset.
          if (in_fmt != FMT_BR) illegal_d = 1'b1;
        end
      end
      S_READ_A: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_PC_UPD;
      S_PC_UPD: begin
        if (run) begin
          state_d   = S_FETCH;
          lat_cnt_d = LAT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state only, so every enable is glitch-free
  // and high exactly one cycle per state visit.
  always_comb begin
    pc_en   = 1'b0;
    done    = 1'b0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en_rf   = 8'h00;
    mux_sel = 4'd0;
    unique case (state_q)
      S_READ_A: begin
        mux_sel = {1'b0, rx};
        en_s    = 1'b1;
      end
      S_EXEC: begin
        mux_sel = (fmt == FMT_I) ? 4'd8 : {1'b0, ry};
        en_c    = 1'b1;
      end
      S_WB: begin
        en_rf = 8'h01 << rx;
      end
      S_PC_UPD: begin
        pc_en = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir      = ir_q;
  assign imm8    = ir_q[12:5];
  assign alu_sel = ir_q[4:2];
  assign busy    = (state_q != S_IDLE);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_bitty_ctrl_fsm.sv
module tb_bitty_ctrl_fsm;

  logic clk;
  logic reset;

  // MEM_LAT = 1 instance
  logic        run1;
  logic [15:0] instr1;
  logic        pc_en1, en_s1, en_c1, busy1, done1, illegal1;
  logic [15:0] ir1;
  logic [3:0]  mux_sel1;
  logic [7:0]  imm81, en_rf1;
  logic [2:0]  alu_sel1;

  // MEM_LAT = 3 instance
  logic        run3;
  logic [15:0] instr3;
  logic        pc_en3, en_s3, en_c3, busy3, done3, illegal3;
  logic [15:0] ir3;
  logic [3:0]  mux_sel3;
  logic [7:0]  imm83, en_rf3;
  logic [2:0]  alu_sel3;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view: {pc_en, done, en_s, en_c, en_rf[7:0], busy, mux_sel[3:0]}
  logic [16:0] obs1, obs3, exp_v;
  assign obs1 = {pc_en1, done1, en_s1, en_c1, en_rf1, busy1, mux_sel1};
  assign obs3 = {pc_en3, done3, en_s3, en_c3, en_rf3, busy3, mux_sel3};

  bitty_ctrl_fsm #(.MEM_LAT(1), .INSTR_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .run(run1), .instr_in(instr1),
    .pc_en(pc_en1), .ir(ir1), .mux_sel(mux_sel1), .imm8(imm81), .alu_sel(alu_sel1),
    .en_s(en_s1), .en_c(en_c1), .en_rf(en_rf1), .busy(busy1), .done(done1),
    .illegal(illegal1)
  );

  bitty_ctrl_fsm #(.MEM_LAT(3), .INSTR_W(16)) u_dut3 (
    .clk(clk), .reset(reset), .run(run3), .instr_in(instr3),
    .pc_en(pc_en3), .ir(ir3), .mux_sel(mux_sel3), .imm8(imm83), .alu_sel(alu_sel3),
    .en_s(en_s3), .en_c(en_c3), .en_rf(en_rf3), .busy(busy3), .done(done3),
    .illegal(illegal3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; run1 = 1'b0; run3 = 1'b0; instr1 = 16'h0000; instr3 = 16'h0000;
    step(); step();
    n_checks++;
    if (obs1 !== 17'h0) begin n_fail++; $display("FAIL reset_outs1: got %h expected %h", obs1, 17'h0); end
    n_checks++;
    if ({ir1, imm81, alu_sel1, illegal1} !== 28'h0) begin
      n_fail++; $display("FAIL reset_ir1: got %h expected %h", {ir1, imm81, alu_sel1, illegal1}, 28'h0);
    end
    n_checks++;
    if (obs3 !== 17'h0) begin n_fail++; $display("FAIL reset_outs3: got %h expected %h", obs3, 17'h0); end
    reset = 1'b0;
    step();
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy1); end
  endtask

  // ADD R1,R1: en_s@t3, en_c@t4, en_rf=02@t5, pc_en+done@t6; run dropped in PC_UPD.
  task automatic test_rtype();
    instr1 = 16'h2400; run1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_v = {(k == 6), (k == 6), (k == 3), (k == 4), (k == 5) ? 8'h02 : 8'h00,
               (k <= 6), (k == 3 || k == 4) ? 4'd1 : 4'd0};
      n_checks++;
      if (obs1 !== exp_v) begin n_fail++; $display("FAIL rtype t%0d: got %h expected %h", k, obs1, exp_v); end
      if (k == 6) run1 = 1'b0;
    end
    n_checks++;
    if ({ir1, alu_sel1} !== {16'h2400, 3'd0}) begin
      n_fail++; $display("FAIL rtype_ir: got %h expected %h", {ir1, alu_sel1}, {16'h2400, 3'd0});
    end
  endtask

  // I-type rx=R3, imm8=2A, alu op 1.
  task automatic test_itype();
    instr1 = 16'h6545; run1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_v = {(k == 6), (k == 6), (k == 3), (k == 4), (k == 5) ? 8'h08 : 8'h00,
               (k <= 6), (k == 3) ? 4'd3 : ((k == 4) ? 4'd8 : 4'd0)};
      n_checks++;
      if (obs1 !== exp_v) begin n_fail++; $display("FAIL itype t%0d: got %h expected %h", k, obs1, exp_v); end
      if (k == 4) begin
        n_checks++;
        if ({imm81, alu_sel1} !== {8'h2A, 3'd1}) begin
          n_fail++; $display("FAIL itype_imm: got %h expected %h", {imm81, alu_sel1}, {8'h2A, 3'd1});
        end
      end
      if (k == 6) run1 = 1'b0;
    end
  endtask

  // Branch: LOAD then PC_UPD, no datapath enables.
  task automatic test_branch();
    instr1 = 16'h0A52; run1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_v = {(k == 3), (k == 3), 1'b0, 1'b0, 8'h00, (k <= 3), 4'd0};
      n_checks++;
      if (obs1 !== exp_v) begin n_fail++; $display("FAIL branch t%0d: got %h expected %h", k, obs1, exp_v); end
      if (k == 3) begin
        n_checks++;
        if ({ir1, illegal1} !== {16'h0A52, 1'b0}) begin
          n_fail++; $display("FAIL branch_ir: got %h expected %h", {ir1, illegal1}, {16'h0A52, 1'b0});
        end
        run1 = 1'b0;
      end
    end
  endtask

  // Illegal word retires as no-op; following legal instruction runs back to back.
  task automatic test_illegal_back_to_back();
    instr1 = 16'hFFFF; run1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = {(k == 3 || k == 9), (k == 3 || k == 9), (k == 6), (k == 7),
               (k == 8) ? 8'h02 : 8'h00, (k <= 9), (k == 6 || k == 7) ? 4'd1 : 4'd0};
      n_checks++;
      if (obs1 !== exp_v) begin n_fail++; $display("FAIL illegal t%0d: got %h expected %h", k, obs1, exp_v); end
      n_checks++;
      if (illegal1 !== (k >= 3)) begin
        n_fail++; $display("FAIL illegal_flag t%0d: got %b expected %b", k, illegal1, (k >= 3));
      end
      if (k == 3) instr1 = 16'h2400;
      if (k == 9) run1 = 1'b0;
    end
  endtask

  // Async reset while in EXEC kills outputs in the same cycle and clears illegal.
  task automatic test_async_reset();
    instr1 = 16'h2400; run1 = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    n_checks++;
    if (en_c1 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_exec: got %b expected 1", en_c1); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs1 !== 17'h0) begin n_fail++; $display("FAIL arst_same_cycle: got %h expected %h", obs1, 17'h0); end
    n_checks++;
    if ({ir1, illegal1} !== 17'h0) begin
      n_fail++; $display("FAIL arst_ir_illegal: got %h expected %h", {ir1, illegal1}, 17'h0);
    end
    @(negedge clk);
    run1 = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (obs1 !== 17'h0) begin n_fail++; $display("FAIL arst_no_pc_en c%0d: got %h expected %h", k, obs1, 17'h0); end
    end
  endtask

  // run drops during READ_A; then MEM_LAT=3 repeat of the R-type case.
  task automatic test_run_drop_and_latency();
    instr1 = 16'h2400; run1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_v = {(k == 6), (k == 6), (k == 3), (k == 4), (k == 5) ? 8'h02 : 8'h00,
               (k <= 6), (k == 3 || k == 4) ? 4'd1 : 4'd0};
      n_checks++;
      if (obs1 !== exp_v) begin n_fail++; $display("FAIL run_drop t%0d: got %h expected %h", k, obs1, exp_v); end
      if (k == 3) run1 = 1'b0;
    end
    instr3 = 16'h2400; run3 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_v = {(k == 8), (k == 8), (k == 5), (k == 6), (k == 7) ? 8'h02 : 8'h00,
               (k <= 8), (k == 5 || k == 6) ? 4'd1 : 4'd0};
      n_checks++;
      if (obs3 !== exp_v) begin n_fail++; $display("FAIL lat3 t%0d: got %h expected %h", k, obs3, exp_v); end
      if (k == 8) run3 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_illegal_back_to_back();
    test_async_reset();
    test_run_drop_and_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
